// File: rtl/accel_mavg_filter.sv
`default_nettype none
// ============================================================================
// Module      : accel_mavg_filter
// Description : Moving-average filter for one signed 16-bit accelerometer axis.
//               It has a power-of-two window and an Avalon-MM register slave.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_mavg_filter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq
);

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_RESULT   = 3'd2;
   localparam logic [2:0] ADDR_COUNT    = 3'd3;
   localparam logic [2:0] ADDR_FLUSH    = 3'd4;
   localparam logic [2:0] ADDR_LAST_RAW = 3'd5;

   logic [15:0]        win_q [0:7];
   logic signed [18:0] sum_q, sum_d;
   logic [3:0]         count_q, count_d;
   logic [2:0]         wr_ptr_q, wr_ptr_d;
   logic [3:0]         ctrl_q, ctrl_d;
   logic [15:0]        result_q, result_d;
   logic [15:0]        last_raw_q, last_raw_d;
   logic               valid_q, valid_d;
   logic               overrun_q, overrun_d;
   logic [15:0]        readdata_q, readdata_d;

   logic               wr_en, flush, ctrl_wr, win_clear, accept, full, new_result;
   logic [3:0]         win_len, count_post;
   logic [2:0]         old_idx;
   logic signed [18:0] new_ext, old_ext, sum_next;
   logic               unused_wdata;

   assign unused_wdata = &{1'b0, writedata[15:4]};

   always_comb begin
      wr_en      = chipselect && !write_n;
      flush      = wr_en && (address == ADDR_FLUSH);
      ctrl_wr    = wr_en && (address == ADDR_CONTROL);
      win_clear  = flush || (ctrl_wr && (writedata[3:2] != ctrl_q[3:2]));
      accept     = sample_valid && ctrl_q[1] && !flush;
      win_len    = 4'd1 << ctrl_q[3:2];
      full       = (count_q == win_len);
      // For N=8 the low bits of N are zero, so the oldest entry is the one being overwritten.
      old_idx    = wr_ptr_q - win_len[2:0];
      new_ext    = {{3{sample_data[15]}}, sample_data};
      old_ext    = full ? {{3{win_q[old_idx][15]}}, win_q[old_idx]} : 19'sd0;
      sum_next   = sum_q + new_ext - old_ext;
      count_post = full ? count_q : count_q + 4'd1;
      new_result = accept && (count_post == win_len);

      sum_d      = sum_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      ctrl_d     = ctrl_q;
      result_d   = result_q;
      last_raw_d = last_raw_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;

      if (accept) begin
         sum_d      = sum_next;
         count_d    = count_post;
         wr_ptr_d   = wr_ptr_q + 3'd1;
         last_raw_d = sample_data;
      end
      if (new_result) begin
         result_d = 16'(sum_next >>> ctrl_q[3:2]);
      end

      // A coincident status clear still lets a new result set valid; overrun sees the old valid.
      if (wr_en && (address == ADDR_STATUS)) begin
         valid_d   = new_result;
         overrun_d = new_result && valid_q;
      end else if (new_result) begin
         valid_d   = 1'b1;
         overrun_d = overrun_q || valid_q;
      end

      if (ctrl_wr) begin
         ctrl_d = writedata[3:0];
      end
      if (win_clear) begin
         sum_d    = 19'sd0;
         count_d  = 4'd0;
         wr_ptr_d = 3'd0;
      end

      case (address)
         ADDR_STATUS:   readdata_d = {14'd0, overrun_q, valid_q};
         ADDR_CONTROL:  readdata_d = {12'd0, ctrl_q};
         ADDR_RESULT:   readdata_d = result_q;
         ADDR_COUNT:    readdata_d = {12'd0, count_q};
         ADDR_LAST_RAW: readdata_d = last_raw_q;
         default:       readdata_d = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q      <= 19'sd0;
         count_q    <= 4'd0;
         wr_ptr_q   <= 3'd0;
         ctrl_q     <= 4'd0;
         result_q   <= 16'd0;
         last_raw_q <= 16'd0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         readdata_q <= 16'd0;
      end else begin
         sum_q      <= sum_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         ctrl_q     <= ctrl_d;
         result_q   <= result_d;
         last_raw_q <= last_raw_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         readdata_q <= readdata_d;
      end
   end

   // Sample storage is not reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (accept) begin
         win_q[wr_ptr_q] <= sample_data;
      end
   end

   assign readdata = readdata_q;
   assign irq      = valid_q && ctrl_q[0];

endmodule
`default_nettype wire

// File: tb/tb_accel_mavg_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_mavg_filter
// Description : Directed bench for accel_mavg_filter, with a sample-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_mavg_filter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = 16'd0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'd0;
   logic [15:0] readdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   accel_mavg_filter dut (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
      .sample_data(sample_data), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // Model: the accepted samples since the last clear, with the window mean taken from the newest N.
   logic signed [15:0] m_q[$];
   logic [3:0]  m_ctrl;
   logic [15:0] m_result, m_last, m_rd;
   logic        m_valid, m_ovr;

   function automatic logic [3:0] m_count();
      int n = 1 << m_ctrl[3:2];
      return (m_q.size() < n) ? 4'(m_q.size()) : 4'(n);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_ctrl = 0; m_result = 0; m_last = 0; m_rd = 0; m_valid = 0; m_ovr = 0;
      end else begin
         int  n, s;
         bit  wr, acc, nr;
         case (address)
            3'd0: m_rd = {14'd0, m_ovr, m_valid};
            3'd1: m_rd = {12'd0, m_ctrl};
            3'd2: m_rd = m_result;
            3'd3: m_rd = {12'd0, m_count()};
            3'd5: m_rd = m_last;
            default: m_rd = 16'd0;
         endcase
         wr  = chipselect && !write_n;
         acc = sample_valid && m_ctrl[1] && !(wr && address == 3'd4);
         nr  = 0;
         n   = 1 << m_ctrl[3:2];
         if (acc) begin
            m_last = sample_data;
            m_q.push_back(sample_data);
            if (m_q.size() > 8) void'(m_q.pop_front());
            if (m_q.size() >= n) begin
               s = 0;
               for (int i = m_q.size() - n; i < m_q.size(); i++) s += m_q[i];
               m_result = 16'(s >>> m_ctrl[3:2]);
               nr = 1;
            end
         end
         if (wr && address == 3'd0) begin
            m_ovr   = nr && m_valid;
            m_valid = nr;
         end else if (nr) begin
            m_ovr   = m_ovr || m_valid;
            m_valid = 1;
         end
         if (wr && address == 3'd1) begin
            if (writedata[3:2] != m_ctrl[3:2]) m_q.delete();
            m_ctrl = writedata[3:0];
         end
         if (wr && address == 3'd4) m_q.delete();
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         check("model_readdata", readdata, m_rd);
         check("model_irq", {15'd0, irq}, {15'd0, m_valid && m_ctrl[0]});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic sample(input logic [15:0] d);
      sample_valid = 1'b1; sample_data = d;
      step();
      sample_valid = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
      address = a;
      step();
      check(name, readdata, exp);
   endtask

   initial begin
      step();
      step();
      reset_n = 1'b1;
      step();
      rd(3'd1, 16'h0000, "reset_control");
      rd(3'd2, 16'h0000, "reset_result");
      check("reset_irq", {15'd0, irq}, 16'd0);

      // N=8, mean of 1..8
      wr_reg(3'd1, 16'h000F);
      for (int i = 1; i <= 7; i++) sample(16'(i));
      check("irq_before_8th", {15'd0, irq}, 16'd0);
      sample(16'd8);
      check("irq_after_8th", {15'd0, irq}, 16'd1);
      rd(3'd2, 16'd4, "result_1to8");
      rd(3'd3, 16'd8, "count_full");
      sample(16'd9);
      rd(3'd2, 16'd5, "result_2to9");
      rd(3'd0, 16'd3, "status_overrun");
      wr_reg(3'd0, 16'hFFFF);
      check("irq_after_clear", {15'd0, irq}, 16'd0);
      rd(3'd0, 16'd0, "status_cleared");

      // N=4: negative floor and large positive
      wr_reg(3'd1, 16'h000B);
      sample(16'hFFFD); sample(16'hFFFD); sample(16'hFFFD); sample(16'hFFFE);
      rd(3'd2, 16'hFFFD, "result_neg_floor");
      for (int i = 0; i < 4; i++) sample(16'h7FFF);
      rd(3'd2, 16'h7FFF, "result_no_wrap");

      // N=2, flush coincident with a sample
      wr_reg(3'd1, 16'h0007);
      sample(16'd5);
      sample_valid = 1'b1; sample_data = 16'd99;
      wr_reg(3'd4, 16'd0);
      sample_valid = 1'b0;
      rd(3'd3, 16'd0, "flush_count");
      rd(3'd5, 16'd5, "flush_last_raw");

      // disabled: samples dropped
      wr_reg(3'd1, 16'h0005);
      for (int i = 0; i < 3; i++) sample(16'd77);
      rd(3'd3, 16'd0, "disabled_count");
      rd(3'd5, 16'd5, "disabled_last_raw");
      rd(3'd2, 16'h7FFF, "disabled_result");
      rd(3'd6, 16'd0, "addr6_zero");

      // reset mid-window
      wr_reg(3'd1, 16'h000F);
      for (int i = 0; i < 5; i++) sample(16'd100);
      rd(3'd3, 16'd5, "count_mid_window");
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_readdata", readdata, 16'd0);
      check("async_reset_irq", {15'd0, irq}, 16'd0);
      step();
      reset_n = 1'b1;
      rd(3'd3, 16'd0, "post_reset_count");
      rd(3'd5, 16'd0, "post_reset_last_raw");
      rd(3'd1, 16'd0, "post_reset_control");
      wr_reg(3'd1, 16'h000F);
      for (int i = 0; i < 7; i++) sample(16'd16);
      rd(3'd0, 16'd0, "post_reset_7_samples");
      sample(16'd16);
      check("post_reset_irq", {15'd0, irq}, 16'd1);
      rd(3'd2, 16'd16, "post_reset_result");
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
